mac_accumulate_unit: RTL and testbench

- Downstream consumer of the MAC input pipeline register stage.
- Multiplies the registered 8-bit operand pair and accumulates products into a wide accumulator.
- Supports signed or unsigned mode per sample, clear and restart, optional saturation and a sticky overflow flag.
- Exposes the result as a full vector and as a byte-selectable view for the 8-bit output pins.

---
 rtl/mac_accumulate_unit.sv | 71 +++++++
 tb/tb_mac_accumulate_unit.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/mac_accumulate_unit.sv
// mac_accumulate_unit: registered 8x8 multiply feeding a saturating/wrapping accumulator with byte-select readout
module mac_accumulate_unit #(
  parameter int ACC_WIDTH = 20,
  parameter bit SATURATE  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           data_a_in,
  input  logic [7:0]           data_b_in,
  input  logic                 clear_mult_in,
  input  logic                 valid_in,
  input  logic                 signed_mode_in,
  input  logic [1:0]           byte_sel,
  output logic [ACC_WIDTH-1:0] acc_out,
  output logic                 acc_valid,
  output logic                 overflow,
  output logic [7:0]           result_byte
);
  localparam logic [ACC_WIDTH-1:0] S_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] S_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  logic [15:0]          prod, p_prod;
  logic                 p_valid, p_clear, p_signed, last_signed;
  logic [ACC_WIDTH-1:0] ext, sat, nxt;
  logic [ACC_WIDTH:0]   sum;
  logic                 ovf;
  logic [23:0]          wide;
  // Low 16 bits of a 16x16 product of sign-extended operands equal the signed 8x8 product
  always_comb begin
    prod = signed_mode_in
      ? {{8{data_a_in[7]}}, data_a_in} * {{8{data_b_in[7]}}, data_b_in}
      : {8'd0, data_a_in} * {8'd0, data_b_in};
    ext  = p_signed ? ACC_WIDTH'($signed(p_prod)) : ACC_WIDTH'(p_prod);
    sum  = {1'b0, acc_out} + {1'b0, ext};
    ovf  = p_signed
      ? (acc_out[ACC_WIDTH-1] == ext[ACC_WIDTH-1]) && (sum[ACC_WIDTH-1] != acc_out[ACC_WIDTH-1])
      : sum[ACC_WIDTH];
    sat  = p_signed ? (ext[ACC_WIDTH-1] ? S_MIN : S_MAX) : '1;
    nxt  = (SATURATE && ovf) ? sat : sum[ACC_WIDTH-1:0];
    wide = last_signed ? 24'($signed(acc_out)) : 24'(acc_out);
    result_byte = byte_sel == 2'd0 ? wide[7:0]
                : byte_sel == 2'd1 ? wide[15:8]
                : byte_sel == 2'd2 ? wide[23:16]
                : {overflow, last_signed, 6'b0};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_prod      <= '0;
      p_valid     <= 1'b0;
      p_clear     <= 1'b0;
      p_signed    <= 1'b0;
      acc_out     <= '0;
      acc_valid   <= 1'b0;
      overflow    <= 1'b0;
      last_signed <= 1'b0;
    end else begin
      p_prod    <= prod;
      p_valid   <= valid_in;
      p_clear   <= clear_mult_in;
      p_signed  <= signed_mode_in;
      acc_valid <= p_valid;
      if (p_valid) last_signed <= p_signed;
      if (p_clear) begin
        acc_out  <= p_valid ? ext : '0;
        overflow <= 1'b0;
      end else if (p_valid) begin
        acc_out  <= nxt;
        overflow <= overflow | ovf;
      end
    end
  end
endmodule

// File: tb/tb_mac_accumulate_unit.sv
// tb_mac_accumulate_unit: directed table plus hand-built sequences against saturating and wrapping instances
module tb_mac_accumulate_unit;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic clr = 1'b0, v = 1'b0, sgn = 1'b0;
  logic [1:0] sel = '0;
  logic [19:0] acc_s, acc_w;
  logic av_s, av_w, ov_s, ov_w;
  logic [7:0] rb_s, rb_w;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  mac_accumulate_unit #(.ACC_WIDTH(20), .SATURATE(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .data_a_in(a), .data_b_in(b), .clear_mult_in(clr),
    .valid_in(v), .signed_mode_in(sgn), .byte_sel(sel),
    .acc_out(acc_s), .acc_valid(av_s), .overflow(ov_s), .result_byte(rb_s));
  mac_accumulate_unit #(.ACC_WIDTH(20), .SATURATE(0)) dut_w (
    .clk(clk), .rst_n(rst_n), .data_a_in(a), .data_b_in(b), .clear_mult_in(clr),
    .valid_in(v), .signed_mode_in(sgn), .byte_sel(sel),
    .acc_out(acc_w), .acc_valid(av_w), .overflow(ov_w), .result_byte(rb_w));
  typedef struct {
    logic [7:0]  a, b;
    logic        c, v, s;
    logic [1:0]  sel;
    logic [19:0] acc;
    logic        av, ov;
    logic [7:0]  rb;
  } vec_t;
  vec_t tv[12];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  task automatic send(input logic [7:0] ia, input logic [7:0] ib, input logic ic, input logic iv, input logic is);
    a = ia; b = ib; clr = ic; v = iv; sgn = is;
    @(posedge clk); #1;
  endtask
  task automatic idle();
    send(8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
  endtask
  initial begin
    tv[0]  = '{8'd3,   8'd4,   1'b1, 1'b1, 1'b0, 2'd0, 20'd12,    1'b1, 1'b0, 8'h0C};
    tv[1]  = '{8'd5,   8'd6,   1'b0, 1'b1, 1'b0, 2'd0, 20'd42,    1'b1, 1'b0, 8'h2A};
    tv[2]  = '{8'hFE,  8'h03,  1'b1, 1'b1, 1'b1, 2'd2, 20'hFFFFA, 1'b1, 1'b0, 8'hFF};
    tv[3]  = '{8'd0,   8'd0,   1'b0, 1'b0, 1'b0, 2'd0, 20'hFFFFA, 1'b0, 1'b0, 8'hFA};
    tv[4]  = '{8'd0,   8'd0,   1'b0, 1'b0, 1'b0, 2'd1, 20'hFFFFA, 1'b0, 1'b0, 8'hFF};
    tv[5]  = '{8'd0,   8'd0,   1'b0, 1'b0, 1'b0, 2'd3, 20'hFFFFA, 1'b0, 1'b0, 8'h40};
    tv[6]  = '{8'h10,  8'h10,  1'b1, 1'b1, 1'b0, 2'd1, 20'h00100, 1'b1, 1'b0, 8'h01};
    tv[7]  = '{8'hFF,  8'h01,  1'b0, 1'b1, 1'b1, 2'd2, 20'h000FF, 1'b1, 1'b0, 8'h00};
    tv[8]  = '{8'd0,   8'd0,   1'b1, 1'b0, 1'b0, 2'd3, 20'h00000, 1'b0, 1'b0, 8'h40};
    tv[9]  = '{8'h80,  8'h80,  1'b1, 1'b1, 1'b1, 2'd3, 20'h04000, 1'b1, 1'b0, 8'h40};
    tv[10] = '{8'h7F,  8'h80,  1'b1, 1'b1, 1'b1, 2'd1, 20'hFC080, 1'b1, 1'b0, 8'hC0};
    tv[11] = '{8'h80,  8'h80,  1'b1, 1'b1, 1'b0, 2'd1, 20'h04000, 1'b1, 1'b0, 8'h40};
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      sel = 2'(i);
      #1 chk("reset_byte", rb_s, 8'h00);
    end
    chk("reset_acc", acc_s, 20'd0);
    chk("reset_valid", av_s, 1'b0);
    chk("reset_ovf", ov_s, 1'b0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 12; i++) begin
      sel = tv[i].sel;
      send(tv[i].a, tv[i].b, tv[i].c, tv[i].v, tv[i].s);
      idle();
      chk($sformatf("vec%0d_acc", i), acc_s, tv[i].acc);
      chk($sformatf("vec%0d_valid", i), av_s, tv[i].av);
      chk($sformatf("vec%0d_ovf", i), ov_s, tv[i].ov);
      chk($sformatf("vec%0d_byte", i), rb_s, tv[i].rb);
    end
    sel = 2'd0;
    send(8'd3, 8'd4, 1'b1, 1'b1, 1'b0);
    send(8'd5, 8'd6, 1'b0, 1'b1, 1'b0);
    chk("b2b_first_acc", acc_s, 20'd12);
    chk("b2b_first_valid", av_s, 1'b1);
    idle();
    chk("b2b_second_acc", acc_s, 20'd42);
    chk("b2b_second_valid", av_s, 1'b1);
    idle();
    chk("b2b_idle_valid", av_s, 1'b0);
    for (int i = 0; i < 16; i++) send(8'hFF, 8'hFF, i == 0, 1'b1, 1'b0);
    idle();
    chk("usat16_acc", acc_s, 20'd1040400);
    chk("usat16_ovf", ov_s, 1'b0);
    send(8'hFF, 8'hFF, 1'b0, 1'b1, 1'b0);
    idle();
    chk("usat17_acc", acc_s, 20'hFFFFF);
    chk("usat17_ovf", ov_s, 1'b1);
    chk("uwrap17_acc", acc_w, 20'd56849);
    chk("uwrap17_ovf", ov_w, 1'b1);
    send(8'hFF, 8'hFF, 1'b0, 1'b1, 1'b0);
    idle();
    chk("usat18_acc", acc_s, 20'hFFFFF);
    chk("usat18_ovf", ov_s, 1'b1);
    chk("uwrap18_acc", acc_w, 20'd121874);
    sel = 2'd3;
    for (int i = 0; i < 31; i++) send(8'h80, 8'h80, i == 0, 1'b1, 1'b1);
    idle();
    chk("ssat31_acc", acc_s, 20'h7C000);
    chk("ssat31_ovf", ov_s, 1'b0);
    send(8'h80, 8'h80, 1'b0, 1'b1, 1'b1);
    idle();
    chk("ssat32_acc", acc_s, 20'h7FFFF);
    chk("ssat32_ovf", ov_s, 1'b1);
    chk("ssat32_status", rb_s, 8'hC0);
    send(8'd0, 8'd0, 1'b1, 1'b0, 1'b0);
    idle();
    chk("clear_acc", acc_s, 20'd0);
    chk("clear_ovf", ov_s, 1'b0);
    chk("clear_valid", av_s, 1'b0);
    sel = 2'd0;
    send(8'd7, 8'd7, 1'b1, 1'b1, 1'b0);
    send(8'd7, 8'd7, 1'b0, 1'b1, 1'b0);
    idle();
    chk("restart_98", acc_s, 20'd98);
    send(8'd2, 8'd2, 1'b1, 1'b1, 1'b0);
    idle();
    chk("restart_4", acc_s, 20'd4);
    a = 8'd9; b = 8'd9; clr = 1'b0; v = 1'b1; sgn = 1'b0;
    @(posedge clk);
    #1 a = 8'd3; b = 8'd3;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_acc", acc_s, 20'd0);
    chk("rst_valid", av_s, 1'b0);
    chk("rst_ovf", ov_s, 1'b0);
    chk("rst_byte", rb_s, 8'h00);
    v = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("post_rst_acc", acc_s, 20'd0);
    chk("post_rst_valid", av_s, 1'b0);
    send(8'd1, 8'd1, 1'b0, 1'b1, 1'b0);
    idle();
    chk("post_rst_first_acc", acc_s, 20'd1);
    chk("post_rst_first_valid", av_s, 1'b1);
    for (int i = 0; i < 16; i++) send(8'hFF, 8'hFF, i == 0, 1'b1, 1'b0);
    send(8'h20, 8'hFF, 1'b0, 1'b1, 1'b0);
    idle();
    chk("wrap_preload_acc", acc_w, 20'hFFFF0);
    chk("wrap_preload_ovf", ov_w, 1'b0);
    send(8'h20, 8'h01, 1'b0, 1'b1, 1'b0);
    idle();
    chk("wrap_acc", acc_w, 20'h00010);
    chk("wrap_ovf", ov_w, 1'b1);
    chk("wrap_sat_acc", acc_s, 20'hFFFFF);
    chk("wrap_sat_ovf", ov_s, 1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
